// File: rtl/wb_sha256_stream.sv
// Wishbone B3 classic slave that streams multi-block messages into a SHA-256
// core. Software fills a 16-word buffer and commits it into a small block
// FIFO. A dispatcher issues init/next to the core, pops each block when it
// completes and latches the final digest when the block marked LAST finishes.

module wb_sha256_stream #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int NUM_BUF    = 2,
    parameter int WORD_ORDER = 1,
    parameter int CNT_W      = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          int_o
);

    // Pointer width is 1 for depths 1..2 and 2 for depths 3..4, so the slot
    // array always matches the pointer width exactly.
    localparam int              PW        = (NUM_BUF > 2) ? 2 : 1;
    localparam int              SLOTS     = 1 << PW;
    localparam logic [PW-1:0]   LAST_SLOT = PW'(NUM_BUF - 1);
    localparam logic [2:0]      DEPTH     = 3'(NUM_BUF);

    typedef struct packed {
        logic         first;
        logic         last;
        logic [511:0] blk;
    } fifo_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       msg_q [16];
    fifo_entry_t       fifo_q [SLOTS];
    fifo_entry_t       head;
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [2:0]        count_q;
    logic              irq_en_q, done_q;
    logic [CNT_W-1:0]  blkcnt_q;
    logic [255:0]      digest_q;

    logic [511:0]      fill_blk;
    logic [31:0]       dig_word [8];
    logic [31:0]       status, rd_data;
    logic [5:0]        idx;
    logic              accept, bad, fifo_full, busy;
    logic              ctrl_wr, msg_wr, do_push, do_abort, do_w1c;
    logic              core_init, core_next, core_ready, core_valid, complete;
    logic [255:0]      core_digest;
    logic              unused_adr;

    assign idx        = wb_adr_i[7:2];
    assign unused_adr = ^{wb_adr_i[AW-1:8], wb_adr_i[1:0]};
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign fifo_full  = (count_q == DEPTH);
    assign busy       = (state_q != ST_IDLE) || (count_q != 3'd0);
    assign status     = {25'b0, count_q, busy, done_q, fifo_full, core_ready};
    assign head       = fifo_q[rd_ptr_q];
    assign int_o      = done_q & irq_en_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    // Map fill-buffer words onto the core block and digest words back out.
    always_comb begin
        fill_blk = '0;
        for (int k = 0; k < 16; k++) begin
            if (WORD_ORDER != 0) fill_blk[511-32*k -: 32] = msg_q[k];
            else                 fill_blk[32*k +: 32]     = msg_q[k];
        end
        for (int k = 0; k < 8; k++) begin
            if (WORD_ORDER != 0) dig_word[k] = digest_q[255-32*k -: 32];
            else                 dig_word[k] = digest_q[32*k +: 32];
        end
    end

    // Address decode: read mux, error detection and write strobes.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        bad     = 1'b0;
        rd_data = '0;
        case (idx) inside
            6'd0: begin
                if (wb_we_i && wb_dat_i[0] && !wb_dat_i[3] && fifo_full) bad = 1'b1;
                rd_data = {23'b0, irq_en_q, 8'b0};
            end
            6'd1:          rd_data = status;
            6'd2: begin
                bad     = wb_we_i;
                rd_data = 32'(blkcnt_q);
            end
            [6'd16:6'd31]: rd_data = msg_q[idx[3:0]];
            [6'd32:6'd39]: begin
                bad     = wb_we_i;
                rd_data = dig_word[idx[2:0]];
            end
            default:       bad = 1'b1;
        endcase
    end

    assign ctrl_wr  = accept & wb_we_i & ~bad & (idx == 6'd0);
    assign do_abort = ctrl_wr & wb_dat_i[3];
    assign do_push  = ctrl_wr & wb_dat_i[0] & ~wb_dat_i[3];
    assign do_w1c   = accept & wb_we_i & ~bad & (idx == 6'd1) & wb_dat_i[2];
    assign msg_wr   = accept & wb_we_i & ~bad & (idx[5:4] == 2'b01);

    // Registered bus response: one ack or err cycle per accepted request.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= accept & ~bad;
            wb_err_o <= accept & bad;
            if (accept) wb_dat_o <= (!wb_we_i && !bad) ? rd_data : '0;
        end
    end

    // Dispatcher next-state and core strobes.
    always_comb begin
        state_d   = state_q;
        core_init = 1'b0;
        core_next = 1'b0;
        complete  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (count_q != 3'd0 && core_ready && !do_abort) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                core_init = head.first;
                core_next = ~head.first;
                state_d   = do_abort ? ST_DRAIN : ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (do_abort)        state_d = ST_DRAIN;
                else if (!core_ready) state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (do_abort) begin
                    state_d = ST_DRAIN;
                end else if (core_ready) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (core_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Dispatcher state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FIFO pointers and occupancy; ABORT empties the queue outright.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || do_abort) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            if (do_push)  wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (complete) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + 3'(do_push) - 3'(complete);
        end
    end

    // FIFO storage is written at the tail on COMMIT.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: block storage carries no reset; an empty FIFO never exposes
        // stale slots, and leaving them out keeps 512-bit words plain flops.
        if (do_push) fifo_q[wr_ptr_q] <= '{first: wb_dat_i[1], last: wb_dat_i[2], blk: fill_blk};
    end

    // Fill buffer with byte-lane writes.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < 16; k++) msg_q[k] <= '0;
        end else if (msg_wr) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel_i[b]) msg_q[idx[3:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
    end

    // Control/status registers, block counter and digest latch.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            blkcnt_q <= '0;
            digest_q <= '0;
        end else begin
            if (ctrl_wr) irq_en_q <= wb_dat_i[8];
            if (do_abort) begin
                done_q   <= 1'b0;
                blkcnt_q <= '0;
            end else begin
                if (complete) blkcnt_q <= head.first ? CNT_W'(1) : blkcnt_q + CNT_W'(1);
                // A completing LAST block outranks a same-cycle W1C of DONE.
                if (complete && head.last && core_valid) begin
                    done_q   <= 1'b1;
                    digest_q <= core_digest;
                end else if (do_w1c) begin
                    done_q <= 1'b0;
                end
            end
        end
    end

    wb_sha256_stream_core u_core (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .init         (core_init),
        .next         (core_next),
        .block        (head.blk),
        .ready        (core_ready),
        .digest       (core_digest),
        .digest_valid (core_valid)
    );

endmodule

// Iterative SHA-256 compression core: one round per cycle. block[511:480]
// is message word 0; digest[255:224] is H0. init starts a fresh hash from
// the IV, next chains from the current digest.
module wb_sha256_stream_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         next,
    input  logic [511:0] block,
    output logic         ready,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic [31:0] h_q [8];
    logic [31:0] v_q [8];
    logic [31:0] v_nxt [8];
    logic [31:0] w_q [16];
    logic [31:0] w_new, t1, t2;
    logic [5:0]  round_q;
    logic        busy_q, start;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign start        = ~busy_q & (init | next);
    assign ready        = ~busy_q;
    assign digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

    // One compression round plus the rolling 16-word message schedule.
    always_comb begin
        t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[round_q] + w_q[0];
        t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        v_nxt[0] = t1 + t2;
        v_nxt[1] = v_q[0];
        v_nxt[2] = v_q[1];
        v_nxt[3] = v_q[2];
        v_nxt[4] = v_q[3] + t1;
        v_nxt[5] = v_q[4];
        v_nxt[6] = v_q[5];
        v_nxt[7] = v_q[6];
        w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    // Working variables and schedule window; loaded on start, never reset.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int k = 0; k < 16; k++) w_q[k] <= block[511-32*k -: 32];
            for (int k = 0; k < 8; k++)  v_q[k] <= init ? IV[k] : h_q[k];
        end else if (busy_q) begin
            for (int k = 0; k < 8; k++)  v_q[k] <= v_nxt[k];
            for (int k = 0; k < 15; k++) w_q[k] <= w_q[k+1];
            w_q[15] <= w_new;
        end
    end

    // Round sequencing and hash-state accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= 1'b0;
            round_q      <= '0;
            digest_valid <= 1'b0;
            for (int k = 0; k < 8; k++) h_q[k] <= '0;
        end else if (start) begin
            busy_q       <= 1'b1;
            round_q      <= '0;
            digest_valid <= 1'b0;
            if (init) for (int k = 0; k < 8; k++) h_q[k] <= IV[k];
        end else if (busy_q) begin
            round_q <= round_q + 6'd1;
            if (round_q == 6'd63) begin
                busy_q       <= 1'b0;
                digest_valid <= 1'b1;
                for (int k = 0; k < 8; k++) h_q[k] <= h_q[k] + v_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_wb_sha256_stream.sv
// Bench for wb_sha256_stream: directed scenarios plus randomized multi-block
// messages, all checked against a plain SHA-256 reference model and a model
// of the fill buffer kept here.

module tb_wb_sha256_stream;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o, int_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] buf_m [16];

    localparam logic [31:0] IV_TAB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    wb_sha256_stream dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .int_o    (int_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Reference SHA-256 over whole 512-bit blocks given as FIPS-order words.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_sha(input logic [31:0] m[$]);
        logic [31:0] h [8];
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, x1, x2;
        for (int i = 0; i < 8; i++) h[i] = IV_TAB[i];
        for (int base = 0; base + 16 <= m.size(); base += 16) begin
            for (int t = 0; t < 16; t++) w[t] = m[base + t];
            for (int t = 16; t < 64; t++)
                w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                x1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
                x2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    task automatic bus(input logic we, input int idx, input logic [31:0] data, input logic [3:0] sel,
                       output logic [31:0] rdata, output logic got_ack, output logic got_err);
        int n = 0;
        wb_adr_i = {24'b0, 6'(idx), 2'b00};
        wb_dat_i = data;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (!(wb_ack_o || wb_err_o) && n < 20);
        if (!(wb_ack_o || wb_err_o)) check("bus_timeout", {31'b0, wb_ack_o | wb_err_o}, 32'd1);
        rdata    = wb_dat_o;
        got_ack  = wb_ack_o;
        got_err  = wb_err_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [31:0] d, output logic e);
        logic [31:0] r;
        logic a;
        bus(1'b1, idx, d, 4'hF, r, a, e);
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        logic a, e;
        bus(1'b0, idx, 32'd0, 4'hF, d, a, e);
    endtask

    task automatic wr_msg(input int k, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        logic a, e;
        bus(1'b1, 16 + k, d, sel, r, a, e);
        for (int b = 0; b < 4; b++)
            if (sel[b]) buf_m[k][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (!int_o && n < 3000) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        check(tag, {31'b0, int_o}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n = 0;
        rd(1, s);
        while (s[3] && n < 500) begin
            rd(1, s);
            n++;
        end
        check(tag, {31'b0, s[3]}, 32'd0);
    endtask

    task automatic wait_not_full();
        logic [31:0] s;
        int n = 0;
        rd(1, s);
        while (s[1] && n < 500) begin
            rd(1, s);
            n++;
        end
        check("fifo_space", {31'b0, s[1]}, 32'd0);
    endtask

    task automatic check_digest(input string tag, input logic [255:0] exp);
        logic [31:0] d;
        for (int k = 0; k < 8; k++) begin
            rd(32 + k, d);
            check($sformatf("%s_d%0d", tag, k), d, exp[255-32*k -: 32]);
        end
    endtask

    task automatic load_abc();
        wr_msg(0, 32'h61626380, 4'hF);
        for (int k = 1; k < 15; k++) wr_msg(k, 32'h0, 4'hF);
        wr_msg(15, 32'h00000018, 4'hF);
    endtask

    initial begin
        logic [31:0] d, s;
        logic        a, e;
        logic [31:0] blocks [$];
        logic [31:0] w1 [16];
        logic [255:0] dig_prev, exp_dig;
        int          nblk;

        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        for (int k = 0; k < 16; k++) buf_m[k] = '0;
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;

        // Reset state of outputs and every register.
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_err", {31'b0, wb_err_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_int", {31'b0, int_o}, 32'd0);
        rd(0, d);  check("rst_ctrl", d, 32'd0);
        rd(1, d);  check("rst_status", d, 32'h1);
        rd(2, d);  check("rst_blkcnt", d, 32'd0);
        for (int k = 0; k < 16; k++) begin
            rd(16 + k, d);
            check($sformatf("rst_msg%0d", k), d, 32'd0);
        end
        check_digest("rst", 256'd0);
        bus(1'b0, 5, 32'd0, 4'hF, d, a, e);
        check("unmapped_err", {31'b0, e}, 32'd1);
        check("unmapped_ack", {31'b0, a}, 32'd0);

        // Single-block "abc".
        load_abc();
        wr(0, 32'h107, e);
        check("abc_commit_err", {31'b0, e}, 32'd0);
        wait_irq("abc_irq");
        check_digest("abc", 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        rd(2, d);  check("abc_blkcnt", d, 32'd1);
        rd(1, d);  check("abc_status", d, 32'h5);
        rd(0, d);  check("ctrl_read", d, 32'h100);

        // Two-block 448-bit message, second block filled while the first runs.
        wr(1, 32'h4, e);
        check("w1c_int", {31'b0, int_o}, 32'd0);
        for (int i = 0; i < 14; i++) begin
            logic [7:0] c0;
            c0 = 8'h61 + 8'(i);
            w1[i] = {c0, c0 + 8'd1, c0 + 8'd2, c0 + 8'd3};
        end
        w1[14] = 32'h80000000;
        w1[15] = 32'h0;
        for (int k = 0; k < 16; k++) wr_msg(k, w1[k], 4'hF);
        wr(0, 32'h103, e);
        check("two_commit1_err", {31'b0, e}, 32'd0);
        for (int k = 0; k < 15; k++) wr_msg(k, 32'h0, 4'hF);
        wr_msg(15, 32'h000001c0, 4'hF);
        wr(0, 32'h105, e);
        check("two_commit2_err", {31'b0, e}, 32'd0);
        rd(1, d);  check("two_status_occ2", d, 32'h2A);
        wait_irq("two_irq");
        check_digest("two", 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
        rd(2, d);  check("two_blkcnt", d, 32'd2);

        // FIFO full: third COMMIT while the core is busy must error.
        wr(1, 32'h4, e);
        wr(0, 32'h107, e);  check("full_c1_err", {31'b0, e}, 32'd0);
        wr(0, 32'h107, e);  check("full_c2_err", {31'b0, e}, 32'd0);
        wr(0, 32'h107, e);  check("full_c3_err", {31'b0, e}, 32'd1);
        rd(1, d);  check("full_status", d, 32'h2A);
        wait_idle("full_idle");
        for (int k = 0; k < 16; k++) blocks.push_back(buf_m[k]);
        dig_prev = ref_sha(blocks);
        blocks.delete();
        check_digest("full", dig_prev);
        rd(2, d);  check("full_blkcnt", d, 32'd1);

        // ABORT while the core is hashing.
        wr(1, 32'h4, e);
        wr(0, 32'h107, e);
        repeat (10) @(posedge wb_clk_i);
        #1;
        wr(0, 32'h108, e);
        check("abort_err", {31'b0, e}, 32'd0);
        rd(1, d);  check("abort_status", d, 32'h08);
        wait_idle("abort_idle");
        rd(1, d);  check("abort_status_idle", d, 32'h01);
        rd(2, d);  check("abort_blkcnt", d, 32'd0);
        check("abort_int", {31'b0, int_o}, 32'd0);
        check_digest("abort_keep", dig_prev);
        load_abc();
        wr(0, 32'h107, e);
        wait_irq("abc2_irq");
        for (int k = 0; k < 16; k++) blocks.push_back(buf_m[k]);
        check_digest("abc2", ref_sha(blocks));
        blocks.delete();

        // Byte lanes, W1C of DONE and writes to read-only registers.
        wr_msg(3, 32'h11223344, 4'hF);
        wr_msg(3, 32'hAABBCCDD, 4'b0101);
        rd(19, d);  check("sel_msg3", d, 32'h11BB33DD);
        check("sel_model", d, buf_m[3]);
        wr(1, 32'h4, e);
        check("w1c_int2", {31'b0, int_o}, 32'd0);
        rd(1, d);  check("w1c_status", d, 32'h1);
        wr(2, 32'h55, e);   check("ro_blkcnt_err", {31'b0, e}, 32'd1);
        rd(2, d);           check("ro_blkcnt_kept", d, 32'd1);
        wr(32, 32'h55, e);  check("ro_digest_err", {31'b0, e}, 32'd1);
        wr(40, 32'h55, e);  check("unmapped40_err", {31'b0, e}, 32'd1);

        // Randomized multi-block messages with random byte-lane overwrites.
        for (int msg = 0; msg < 4; msg++) begin
            wr(1, 32'h4, e);
            nblk = int'($urandom_range(1, 3));
            for (int b = 0; b < nblk; b++) begin
                for (int k = 0; k < 16; k++) begin
                    wr_msg(k, $urandom, 4'hF);
                    if ($urandom_range(0, 3) == 0) wr_msg(k, $urandom, 4'($urandom_range(0, 15)));
                end
                s = 32'($urandom_range(0, 15));
                rd(16 + int'(s[3:0]), d);
                check($sformatf("rnd%0d_msg%0d", msg, s), d, buf_m[s[3:0]]);
                for (int k = 0; k < 16; k++) blocks.push_back(buf_m[k]);
                wait_not_full();
                wr(0, 32'h101 | (b == 0 ? 32'h2 : 32'h0) | (b == nblk - 1 ? 32'h4 : 32'h0), e);
                check($sformatf("rnd%0d_commit%0d", msg, b), {31'b0, e}, 32'd0);
            end
            exp_dig = ref_sha(blocks);
            blocks.delete();
            wait_irq($sformatf("rnd%0d_irq", msg));
            check_digest($sformatf("rnd%0d", msg), exp_dig);
            rd(2, d);  check($sformatf("rnd%0d_blkcnt", msg), d, 32'(nblk));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
